// File: rtl/otter_decode_stage_if.sv
// Fetch/decode/execute handshake bundle for the OTTER decode stage.
// slave is the decode stage's view; master is the surrounding pipeline.
interface otter_decode_stage_if #(
    parameter int PC_W = 32
);
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_ir;
    logic [PC_W-1:0] if_pc;
    logic            flush;
    logic            int_req;

    logic            de_valid;
    logic            ex_ready;
    logic [PC_W-1:0] de_pc;
    logic [4:0]      de_rs1;
    logic [4:0]      de_rs2;
    logic [4:0]      de_rd;
    logic            de_regwrite;
    logic            de_memwrite;
    logic            de_memread2;
    logic            de_alu_srca;
    logic [1:0]      de_alu_srcb;
    logic [1:0]      de_rf_wr_sel;
    logic [4:0]      de_alu_fun;
    logic [2:0]      de_pcsource;
    logic [1:0]      de_msize;
    logic            de_msign;
    logic [2:0]      de_br_func3;
    logic            de_is_branch;
    logic            de_int;
    logic            de_illegal;

    modport master (
        output if_valid, if_ir, if_pc, flush, int_req, ex_ready,
        input  if_ready, de_valid, de_pc, de_rs1, de_rs2, de_rd,
               de_regwrite, de_memwrite, de_memread2, de_alu_srca,
               de_alu_srcb, de_rf_wr_sel, de_alu_fun, de_pcsource,
               de_msize, de_msign, de_br_func3, de_is_branch, de_int,
               de_illegal
    );

    modport slave (
        input  if_valid, if_ir, if_pc, flush, int_req, ex_ready,
        output if_ready, de_valid, de_pc, de_rs1, de_rs2, de_rd,
               de_regwrite, de_memwrite, de_memread2, de_alu_srca,
               de_alu_srcb, de_rf_wr_sel, de_alu_fun, de_pcsource,
               de_msize, de_msign, de_br_func3, de_is_branch, de_int,
               de_illegal
    );
endinterface

// File: rtl/otter_decode_stage.sv
// OTTER decode stage: decode on accept, 2-entry skid FIFO, load-use bubbles, interrupt tagging.
// Define OTTER_MEXT_EN to decode the RV32M multiply/divide group instead of flagging it illegal.
module otter_decode_stage #(
    parameter int PC_W        = 32,
    parameter int HAZ_BUBBLES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    otter_decode_stage_if.slave bus
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            regwrite;
        logic            memwrite;
        logic            memread2;
        logic            alu_srca;
        logic [1:0]      alu_srcb;
        logic [1:0]      rf_wr_sel;
        logic [4:0]      alu_fun;
        logic [2:0]      pcsource;
        logic [1:0]      msize;
        logic            msign;
        logic [2:0]      br_func3;
        logic            is_branch;
        logic            irq;
        logic            illegal;
        logic            use_rs1;
        logic            use_rs2;
    } entry_t;

    state_t     state;
    entry_t     slot0;
    entry_t     slot1;
    entry_t     dec;
    logic       int_pend;
    logic       ld_valid;
    logic [4:0] ld_rd;
    logic [1:0] bub_cnt;
    logic       legal;
    logic       accept;
    logic       issue;
    logic       hazard_hit;
    logic       bubble;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opc = bus.if_ir[6:0];
    assign f3  = bus.if_ir[14:12];
    assign f7  = bus.if_ir[31:25];

    // Instructions are decoded once on entry; the FIFO holds decoded control words.
    always_comb begin
        dec           = '0;
        legal         = 1'b1;
        dec.pc        = bus.if_pc;
        dec.rs1       = bus.if_ir[19:15];
        dec.rs2       = bus.if_ir[24:20];
        dec.rd        = bus.if_ir[11:7];
        dec.irq       = int_pend | bus.int_req;
        dec.rf_wr_sel = 2'd3;
        dec.use_rs1   = 1'b1;
        dec.use_rs2   = 1'b1;
        case (opc)
            OPC_LUI: begin
                dec.alu_fun  = 5'b01001;
                dec.alu_srca = 1'b1;
                dec.use_rs1  = 1'b0;
                dec.use_rs2  = 1'b0;
            end
            OPC_AUIPC: begin
                dec.alu_srca = 1'b1;
                dec.alu_srcb = 2'd3;
                dec.use_rs1  = 1'b0;
                dec.use_rs2  = 1'b0;
            end
            OPC_JAL: begin
                dec.alu_srcb  = 2'd1;
                dec.rf_wr_sel = 2'd0;
                dec.pcsource  = 3'd3;
                dec.use_rs1   = 1'b0;
                dec.use_rs2   = 1'b0;
            end
            OPC_JALR: begin
                dec.rf_wr_sel = 2'd0;
                dec.pcsource  = 3'd1;
                dec.use_rs2   = 1'b0;
            end
            OPC_BRANCH: begin
                dec.pcsource  = 3'd2;
                dec.is_branch = 1'b1;
                dec.br_func3  = f3;
            end
            OPC_LOAD: begin
                dec.alu_srcb  = 2'd1;
                dec.rf_wr_sel = 2'd2;
                dec.memread2  = 1'b1;
                dec.msize     = f3[1:0];
                dec.msign     = ~f3[2];
                dec.use_rs2   = 1'b0;
            end
            OPC_STORE: begin
                dec.alu_srcb = 2'd2;
                dec.memwrite = 1'b1;
                dec.msize    = f3[1:0];
                dec.msign    = ~f3[2];
            end
            OPC_IMM: begin
                dec.alu_srcb = 2'd1;
                dec.alu_fun  = (f3 == 3'b101) ? {1'b0, f7[5], f3} : {2'b00, f3};
                dec.use_rs2  = 1'b0;
            end
            OPC_OP: begin
                if (f7 == 7'b0000001) begin
`ifdef OTTER_MEXT_EN
                    dec.alu_fun = {2'b10, f3};
`else
                    legal = 1'b0;
`endif
                end else begin
                    dec.alu_fun = {1'b0, f7[5], f3};
                end
            end
            OPC_SYSTEM: begin
                dec.alu_fun   = 5'b01001;
                dec.rf_wr_sel = 2'd1;
                if (f3 == 3'b000) dec.pcsource = 3'd5;
            end
            default: legal = 1'b0;
        endcase
        dec.illegal  = ~legal;
        dec.regwrite = legal && (opc != OPC_BRANCH) && (opc != OPC_STORE) && (dec.rd != 5'd0);
        if (dec.irq) dec.pcsource = 3'd4;
    end

    // A recorded load is compared once against the next head; a hit starts the bubble run.
    assign hazard_hit = ld_valid && (state != EMPTY) && (bub_cnt == 2'd0) &&
                        ((slot0.use_rs1 && (slot0.rs1 == ld_rd)) ||
                         (slot0.use_rs2 && (slot0.rs2 == ld_rd)));
    assign bubble       = (bub_cnt != 2'd0) || hazard_hit;
    assign bus.de_valid = (state != EMPTY) && !bubble;
    assign bus.if_ready = (state != TWO);
    assign accept       = bus.if_valid && bus.if_ready && !bus.flush;
    assign issue        = bus.de_valid && bus.ex_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            slot0    <= '0;
            slot1    <= '0;
            int_pend <= 1'b0;
            ld_valid <= 1'b0;
            ld_rd    <= 5'd0;
            bub_cnt  <= 2'd0;
        end else begin
            if (accept)           int_pend <= 1'b0;
            else if (bus.int_req) int_pend <= 1'b1;

            if (bus.flush) begin
                state    <= EMPTY;
                bub_cnt  <= 2'd0;
                ld_valid <= 1'b0;
            end else begin
                if (bub_cnt != 2'd0) bub_cnt <= bub_cnt - 2'd1;
                else if (hazard_hit) bub_cnt <= 2'(HAZ_BUBBLES - 1);

                if (issue) begin
                    ld_valid <= slot0.memread2 && (slot0.rd != 5'd0);
                    ld_rd    <= slot0.rd;
                end else if (ld_valid && (state != EMPTY) && (bub_cnt == 2'd0)) begin
                    ld_valid <= 1'b0;
                end

                case (state)
                    EMPTY: if (accept) begin
                        slot0 <= dec;
                        state <= ONE;
                    end
                    ONE: begin
                        if (accept && issue) begin
                            slot0 <= dec;
                        end else if (accept) begin
                            slot1 <= dec;
                            state <= TWO;
                        end else if (issue) begin
                            state <= EMPTY;
                        end
                    end
                    TWO: if (issue) begin
                        slot0 <= slot1;
                        state <= ONE;
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

    assign bus.de_pc        = slot0.pc;
    assign bus.de_rs1       = slot0.rs1;
    assign bus.de_rs2       = slot0.rs2;
    assign bus.de_rd        = slot0.rd;
    assign bus.de_regwrite  = slot0.regwrite;
    assign bus.de_memwrite  = slot0.memwrite;
    assign bus.de_memread2  = slot0.memread2;
    assign bus.de_alu_srca  = slot0.alu_srca;
    assign bus.de_alu_srcb  = slot0.alu_srcb;
    assign bus.de_rf_wr_sel = slot0.rf_wr_sel;
    assign bus.de_alu_fun   = slot0.alu_fun;
    assign bus.de_pcsource  = slot0.pcsource;
    assign bus.de_msize     = slot0.msize;
    assign bus.de_msign     = slot0.msign;
    assign bus.de_br_func3  = slot0.br_func3;
    assign bus.de_is_branch = slot0.is_branch;
    assign bus.de_int       = slot0.irq;
    assign bus.de_illegal   = slot0.illegal;
endmodule

// File: tb/tb_otter_decode_stage.sv
// Scoreboard bench for otter_decode_stage: directed vectors with hand-decoded expectations.
// Honours OTTER_MEXT_EN for the MUL vector.
module tb_otter_decode_stage;
    localparam int HAZ = 2;

    typedef struct packed {
        logic [31:0] ir;
        logic [4:0]  rd;
        logic [4:0]  alu_fun;
        logic [1:0]  srcb;
        logic [1:0]  wsel;
        logic        rw;
        logic        mw;
        logic        mr;
        logic [2:0]  pcs;
        logic [1:0]  msize;
        logic        msign;
        logic        br;
        logic [2:0]  bf3;
        logic        ill;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        vec_t        v;
        logic        irq;
    } exp_t;

    localparam vec_t V_ADD    = '{32'h002081B3, 5'd3, 5'b00000, 2'd0, 2'd3, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0};
    localparam vec_t V_SUB    = '{32'h40208233, 5'd4, 5'b01000, 2'd0, 2'd3, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0};
    localparam vec_t V_SRAI   = '{32'h4030D393, 5'd7, 5'b01101, 2'd1, 2'd3, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0};
    localparam vec_t V_NOP    = '{32'h00000013, 5'd0, 5'b00000, 2'd1, 2'd3, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0};
    localparam vec_t V_SW     = '{32'h0020A223, 5'd4, 5'b00000, 2'd2, 2'd3, 1'b0, 1'b1, 1'b0, 3'd0, 2'd2, 1'b1, 1'b0, 3'd0, 1'b0};
    localparam vec_t V_BNE    = '{32'h00209463, 5'd8, 5'b00000, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 3'd2, 2'd0, 1'b0, 1'b1, 3'd1, 1'b0};
    localparam vec_t V_MRET   = '{32'h30200073, 5'd0, 5'b01001, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 3'd5, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0};
    localparam vec_t V_LBU    = '{32'h0000C403, 5'd8, 5'b00000, 2'd1, 2'd2, 1'b1, 1'b0, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0};
    localparam vec_t V_ILL    = '{32'h0000007F, 5'd0, 5'b00000, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b1};
    localparam vec_t V_LW     = '{32'h0000A283, 5'd5, 5'b00000, 2'd1, 2'd2, 1'b1, 1'b0, 1'b1, 3'd0, 2'd2, 1'b1, 1'b0, 3'd0, 1'b0};
    localparam vec_t V_ADD605 = '{32'h00028333, 5'd6, 5'b00000, 2'd0, 2'd3, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0};
    localparam vec_t V_ADD612 = '{32'h00208333, 5'd6, 5'b00000, 2'd0, 2'd3, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0};
    localparam vec_t V_LUI    = '{32'h000283B7, 5'd7, 5'b01001, 2'd0, 2'd3, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0};
    localparam vec_t V_JAL    = '{32'h000000EF, 5'd1, 5'b00000, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 3'd3, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0};
`ifdef OTTER_MEXT_EN
    localparam vec_t V_MUL    = '{32'h023100B3, 5'd1, 5'b10000, 2'd0, 2'd3, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0};
`else
    localparam vec_t V_MUL    = '{32'h023100B3, 5'd1, 5'b00000, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b1};
`endif

    logic   clk;
    logic   rst_n;
    exp_t   exp_q[$];
    logic   pend;
    int     checks;
    int     errors;
    int     cyc;
    int     prev_issue;
    int     last_issue;
    logic   stall_valid;
    logic [31:0] stall_pc;
    logic [4:0]  stall_rd;

    otter_decode_stage_if #(.PC_W(32)) bus ();

    otter_decode_stage #(.PC_W(32), .HAZ_BUBBLES(HAZ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic push_expected(input vec_t v, input logic [31:0] pc, input logic irq);
        exp_t e;
        e.pc  = pc;
        e.v   = v;
        e.irq = irq;
        if (irq) e.v.pcs = 3'd4;
        exp_q.push_back(e);
    endtask

    // One fetch-side cycle; entered just after a rising edge, returns just after the next.
    task automatic apply_stimulus(input vec_t v, input logic [31:0] pc, input logic valid,
                                  input logic irq, input logic flush, output logic accepted);
        bus.if_valid = valid;
        bus.if_ir    = v.ir;
        bus.if_pc    = pc;
        bus.int_req  = irq;
        bus.flush    = flush;
        @(negedge clk);
        accepted = valid && bus.if_ready && !flush;
        if (accepted) begin
            push_expected(v, pc, pend | irq);
            pend = 1'b0;
        end else if (irq) begin
            pend = 1'b1;
        end
        if (flush) exp_q.delete();
        @(posedge clk);
        #1;
        bus.if_valid = 1'b0;
        bus.int_req  = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic send(input vec_t v, input logic [31:0] pc, input logic irq);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 40) begin
            apply_stimulus(v, pc, 1'b1, (tries == 0) ? irq : 1'b0, 1'b0, acc);
            tries++;
        end
        if (!acc) check_output("send_accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_output("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every completed DE handshake must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                stall_valid = 1'b0;
            end else begin
                if (stall_valid && bus.de_valid) begin
                    check_output("stall_pc_stable", bus.de_pc, stall_pc);
                    check_output("stall_rd_stable", 32'(bus.de_rd), 32'(stall_rd));
                end
                if (bus.de_valid && bus.ex_ready) begin
                    prev_issue = last_issue;
                    last_issue = cyc;
                    if (exp_q.size() == 0) begin
                        check_output("unexpected_issue_pc", bus.de_pc, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("pc",        bus.de_pc,                e.pc);
                        check_output("rd",        32'(bus.de_rd),           32'(e.v.rd));
                        check_output("alu_fun",   32'(bus.de_alu_fun),      32'(e.v.alu_fun));
                        check_output("alu_srcb",  32'(bus.de_alu_srcb),     32'(e.v.srcb));
                        check_output("rf_wr_sel", 32'(bus.de_rf_wr_sel),    32'(e.v.wsel));
                        check_output("regwrite",  32'(bus.de_regwrite),     32'(e.v.rw));
                        check_output("memwrite",  32'(bus.de_memwrite),     32'(e.v.mw));
                        check_output("memread2",  32'(bus.de_memread2),     32'(e.v.mr));
                        check_output("pcsource",  32'(bus.de_pcsource),     32'(e.v.pcs));
                        check_output("msize",     32'(bus.de_msize),        32'(e.v.msize));
                        check_output("msign",     32'(bus.de_msign),        32'(e.v.msign));
                        check_output("is_branch", 32'(bus.de_is_branch),    32'(e.v.br));
                        check_output("br_func3",  32'(bus.de_br_func3),     32'(e.v.bf3));
                        check_output("de_int",    32'(bus.de_int),          32'(e.irq));
                        check_output("illegal",   32'(bus.de_illegal),      32'(e.v.ill));
                    end
                end
                stall_valid = bus.de_valid && !bus.ex_ready;
                stall_pc    = bus.de_pc;
                stall_rd    = bus.de_rd;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic acc;
        logic [31:0] rdy [3];
        checks = 0; errors = 0; cyc = 0; prev_issue = 0; last_issue = 0;
        pend = 1'b0; stall_valid = 1'b0; stall_pc = '0; stall_rd = '0;
        rst_n = 1'b0;
        bus.if_valid = 1'b0; bus.if_ir = '0; bus.if_pc = '0;
        bus.flush = 1'b0; bus.int_req = 1'b0; bus.ex_ready = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check_output("rst_de_valid",  32'(bus.de_valid),    32'd0);
        check_output("rst_rd",        32'(bus.de_rd),       32'd0);
        check_output("rst_alu_fun",   32'(bus.de_alu_fun),  32'd0);
        check_output("rst_illegal",   32'(bus.de_illegal),  32'd0);
        check_output("rst_pcsource",  32'(bus.de_pcsource), 32'd0);
        check_output("rst_regwrite",  32'(bus.de_regwrite), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("rst_if_ready",  32'(bus.if_ready),    32'd1);
        @(posedge clk); #1;

        // Single ADD into an empty buffer: valid on the following cycle
        bus.ex_ready = 1'b1;
        send(V_ADD, 32'h100, 1'b0);
        @(negedge clk);
        check_output("latency_de_valid", 32'(bus.de_valid), 32'd1);
        @(posedge clk); #1;
        drain();

        // Back-to-back decode mix
        send(V_SUB,  32'h104, 1'b0);
        send(V_SRAI, 32'h108, 1'b0);
        send(V_NOP,  32'h10C, 1'b0);
        send(V_SW,   32'h110, 1'b0);
        send(V_BNE,  32'h114, 1'b0);
        send(V_MRET, 32'h118, 1'b0);
        send(V_LBU,  32'h11C, 1'b0);
        send(V_ILL,  32'h120, 1'b0);
        send(V_MUL,  32'h124, 1'b0);
        drain();

        // Skid buffer fills with execute stalled, then drains in order
        bus.ex_ready = 1'b0;
        apply_stimulus(V_ADD,  32'h200, 1'b1, 1'b0, 1'b0, acc); rdy[0] = 32'(acc);
        apply_stimulus(V_SUB,  32'h204, 1'b1, 1'b0, 1'b0, acc); rdy[1] = 32'(acc);
        apply_stimulus(V_SRAI, 32'h208, 1'b1, 1'b0, 1'b0, acc); rdy[2] = 32'(acc);
        check_output("fill_accept_1", rdy[0], 32'd1);
        check_output("fill_accept_2", rdy[1], 32'd1);
        check_output("fill_accept_3_blocked", rdy[2], 32'd0);
        bus.ex_ready = 1'b1;
        send(V_SRAI, 32'h208, 1'b0);
        drain();

        // Load-use hazard, then two non-dependent followers
        send(V_LW,     32'h300, 1'b0);
        send(V_ADD605, 32'h304, 1'b0);
        drain();
        check_output("hazard_issue_gap", 32'(last_issue - prev_issue), 32'(HAZ + 1));
        send(V_LW,     32'h308, 1'b0);
        send(V_ADD612, 32'h30C, 1'b0);
        drain();
        check_output("no_hazard_gap", 32'(last_issue - prev_issue), 32'd1);
        send(V_LW,     32'h310, 1'b0);
        send(V_LUI,    32'h314, 1'b0);
        drain();
        check_output("lui_no_source_gap", 32'(last_issue - prev_issue), 32'd1);

        // Interrupt pending while empty, then coincident with an accept
        apply_stimulus(V_NOP, 32'h0, 1'b0, 1'b1, 1'b0, acc);
        send(V_JAL,  32'h400, 1'b0);
        send(V_ADD,  32'h404, 1'b0);
        send(V_SUB,  32'h408, 1'b1);
        send(V_SRAI, 32'h40C, 1'b0);
        drain();

        // Flush from full, with an interrupt pulse landing in the flush cycle
        bus.ex_ready = 1'b0;
        send(V_ADD, 32'h500, 1'b0);
        send(V_SUB, 32'h504, 1'b0);
        apply_stimulus(V_SRAI, 32'h508, 1'b1, 1'b1, 1'b1, acc);
        @(negedge clk);
        check_output("flush_de_valid", 32'(bus.de_valid), 32'd0);
        check_output("flush_if_ready", 32'(bus.if_ready), 32'd1);
        @(posedge clk); #1;
        bus.ex_ready = 1'b1;
        apply_stimulus(V_SW, 32'h50C, 1'b1, 1'b0, 1'b1, acc);
        @(negedge clk);
        check_output("flush_drops_input", 32'(bus.de_valid), 32'd0);
        @(posedge clk); #1;
        send(V_ADD, 32'h510, 1'b0);
        drain();

        // Reset in the middle of a stalled stream
        bus.ex_ready = 1'b0;
        send(V_ADD, 32'h600, 1'b0);
        send(V_SUB, 32'h604, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("midrst_de_valid", 32'(bus.de_valid), 32'd0);
        check_output("midrst_de_pc",    bus.de_pc,         32'd0);
        exp_q.delete();
        pend = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("midrst_if_ready", 32'(bus.if_ready), 32'd1);
        @(posedge clk); #1;
        bus.ex_ready = 1'b1;
        send(V_JAL, 32'h608, 1'b0);
        drain();
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/otter_decode_stage.md
OTTER_DECODE_STAGE -- requirements
Module: otter_decode_stage

Interface
REQ-001 Parameter PC_W, default 32: width of the PC carried with each instruction.
REQ-002 Parameter HAZ_BUBBLES, default 1, range 1..3: bubble cycles inserted on a load-use hazard.
REQ-003 CLK  in  1: single clock; all state on rising edge.
REQ-004 RST_N  in  1: reset, asynchronous, active-low.
REQ-005 IF_VALID  in  1; IF_READY  out  1: fetch-side handshake.
REQ-006 IF_IR  in  32; IF_PC  in  PC_W: instruction word and its PC.
REQ-007 FLUSH  in  1: discard all held and incoming instructions.
REQ-008 INT_REQ  in  1: single-cycle interrupt-taken pulse.
REQ-009 DE_VALID  out  1; EX_READY  in  1: execute-side handshake.
REQ-010 DE_PC  out  PC_W; DE_RS1, DE_RS2, DE_RD  out  5 each: operand and destination indices.
REQ-011 DE_REGWRITE, DE_MEMWRITE, DE_MEMREAD2, DE_ALU_SRCA  out  1 each.
REQ-012 DE_ALU_SRCB  out  2; DE_RF_WR_SEL  out  2; DE_ALU_FUN  out  5; DE_PCSOURCE  out  3.
REQ-013 DE_MSIZE  out  2; DE_MSIGN  out  1; DE_BR_FUNC3  out  3; DE_IS_BRANCH, DE_INT, DE_ILLEGAL  out  1 each.

Function
REQ-014 Decode: LUI/SYSTEM ALU_FUN 01001; OP {0,f7[5],f3}; OP_IMM {0,f7[5],f3} when f3=101, else {00,f3}; all others 00000.
REQ-015 ALU_SRCA=1 for LUI/AUIPC; ALU_SRCB: STORE 2, LOAD/JAL/OP_IMM 1, AUIPC 3, else 0.
REQ-016 RF_WR_SEL: JAL/JALR 0, LOAD 2, SYSTEM 1, else 3; REGWRITE=0 for BRANCH/STORE and when RD=0.
REQ-017 PCSOURCE: JAL 3, JALR 1, BRANCH 2, SYSTEM with f3=000 (mret) 5, else 0; branch condition not resolved here (DE_IS_BRANCH, DE_BR_FUNC3 go to execute).
REQ-018 DE_MSIZE=f3[1:0], DE_MSIGN=~f3[2] for LOAD/STORE, else 0.
REQ-019 Opcode outside the ten base classes: DE_ILLEGAL=1, REGWRITE=MEMWRITE=MEMREAD2=0.
REQ-020 Buffer: 2-entry skid, states EMPTY, ONE, TWO; IF_READY = (state!=TWO) registered-free combinational from state only.
REQ-021 Transitions: accept-only +1; issue-only -1; accept and issue same cycle holds state; DE_VALID = (state!=EMPTY) && no bubble.
REQ-022 Ordering strictly FIFO; DE_* outputs stable while DE_VALID=1 and EX_READY=0.
REQ-023 Latency: instruction accepted in cycle N appears on DE_* in cycle N+1 when buffer was EMPTY.
REQ-024 Hazard: when an issued entry was LOAD with RD!=0 and the new head has RS1 or RS2 equal to that RD, DE_VALID forced 0 for exactly HAZ_BUBBLES cycles via down-counter; RS compares ignored for LUI/AUIPC/JAL (no source) and RS2 ignored for OP_IMM/LOAD/JALR.
REQ-025 INT_REQ sets pending flag; next accepted instruction gets DE_INT=1, DE_PCSOURCE=4 (overrides REQ-017), flag cleared on that accept; INT_REQ coincident with accept marks that same instruction.
REQ-026 FLUSH: next state EMPTY, bubble counter and hazard record cleared, IF input in the FLUSH cycle dropped; pending interrupt flag retained.

Reset
REQ-027 RST_N low: state EMPTY, DE_VALID=0, IF_READY=1 after release, bubble counter 0, hazard record invalid, interrupt pending 0, all DE_* fields 0.
REQ-028 Reset mid-transaction discards all held entries without emitting them.

Configuration
REQ-029 Macro OTTER_MEXT_EN defined: OP with f7=0000001 decodes ALU_FUN {1,0,f3}, REGWRITE=1, DE_ILLEGAL=0.
REQ-030 Macro OTTER_MEXT_EN undefined: OP with f7=0000001 sets DE_ILLEGAL=1, REGWRITE=0; ALU_FUN[4] always 0.

Verification
REQ-031 ADD x3,x1,x2 (0x002081B3) into EMPTY, EX_READY=1 -> next cycle DE_VALID=1, ALU_FUN=00000, RD=3, RF_WR_SEL=3, REGWRITE=1.
REQ-032 EX_READY=0, three back-to-back IF_VALID -> IF_READY drops after two accepts; raising EX_READY issues both in order, no loss or duplicate.
REQ-033 LW x5,0(x1) then ADD x6,x5,x0 with HAZ_BUBBLES=2 -> exactly 2 cycles DE_VALID=0 between the two issues.
REQ-034 INT_REQ pulse while EMPTY, then JAL -> that JAL issues with DE_INT=1, DE_PCSOURCE=4; following instruction DE_INT=0.
REQ-035 State TWO, FLUSH=1 with IF_VALID=1 -> next cycle DE_VALID=0, IF_READY=1, nothing from before the flush issued.
REQ-036 MUL x1,x2,x3 (0x023100B3) -> ALU_FUN=10000 with OTTER_MEXT_EN, DE_ILLEGAL=1 without; RST_N low mid-stream -> DE_VALID=0 immediately.
